// File: rtl/univ_shift_reg_pkg.sv
// Shared command encodings and FSM state for the universal shift register.
package usr_pkg;

   typedef enum logic [2:0] {
      OP_NOP  = 3'd0,
      OP_LOAD = 3'd1,
      OP_CLR  = 3'd2,
      OP_SHL  = 3'd3,
      OP_SHR  = 3'd4,
      OP_ASR  = 3'd5,
      OP_ROL  = 3'd6,
      OP_ROR  = 3'd7
   } op_e;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } st_e;

   // Shift and rotate ops occupy the top of the encoding space.
   function automatic logic is_shift(input op_e o);
      return o >= OP_SHL;
   endfunction

endpackage

// File: rtl/univ_shift_reg_shift_step.sv
// One-position shift/rotate of a WIDTH-bit word; bit_out is the bit leaving the word.
module shift_step
   import usr_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  op_e              op,
   input  logic             sin,
   input  logic [WIDTH-1:0] q,
   output logic [WIDTH-1:0] q_nxt,
   output logic             bit_out
);

   always_comb begin
      q_nxt   = q;
      bit_out = 1'b0;
      case (op)
         OP_SHL: begin q_nxt = {q[WIDTH-2:0], sin};        bit_out = q[WIDTH-1]; end
         OP_SHR: begin q_nxt = {sin, q[WIDTH-1:1]};        bit_out = q[0];       end
         OP_ASR: begin q_nxt = {q[WIDTH-1], q[WIDTH-1:1]}; bit_out = q[0];       end
         OP_ROL: begin q_nxt = {q[WIDTH-2:0], q[WIDTH-1]}; bit_out = q[WIDTH-1]; end
         OP_ROR: begin q_nxt = {q[0], q[WIDTH-1:1]};       bit_out = q[0];       end
         default: ;
      endcase
   end

endmodule

// File: rtl/univ_shift_reg.sv
// Universal register: load/clear/shift/rotate with VALID/READY commands and a DONE pulse.
// Define SHIFT_FAST_EN for the single-cycle barrel build; default is one bit per clock.
module univ_shift_reg
   import usr_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int AW    = $clog2(WIDTH+1)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] d,
   input  logic             sin,
   input  logic [2:0]       op,
   input  logic [AW-1:0]    amt,
   input  logic             valid,
   output logic             ready,
   output logic [WIDTH-1:0] q,
   output logic [WIDTH-1:0] nq,
   output logic             sout,
   output logic             done,
   output logic             zero
);

   logic [WIDTH-1:0] q_r;
   logic             sout_r;
   logic             done_r;
   logic [AW-1:0]    amt_clamp;
   op_e              op_in;

   assign op_in     = op_e'(op);
   assign amt_clamp = (amt > AW'(WIDTH)) ? AW'(WIDTH) : amt;

   assign q    = q_r;
   assign nq   = ~q_r;
   assign sout = sout_r;
   assign done = done_r;
   assign zero = (q_r == '0);

`ifdef SHIFT_FAST_EN
   // Chain of WIDTH single steps; tap k holds the result of a k-position op.
   logic [WIDTH:0][WIDTH-1:0] chain_q;
   logic [WIDTH:1]            chain_out;

   assign chain_q[0] = q_r;
   assign ready      = 1'b1;

   for (genvar i = 0; i < WIDTH; i++) begin : g_chain
      shift_step #(.WIDTH(WIDTH)) u_step (
         .op      (op_in),
         .sin     (sin),
         .q       (chain_q[i]),
         .q_nxt   (chain_q[i+1]),
         .bit_out (chain_out[i+1])
      );
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q_r    <= '0;
         sout_r <= 1'b0;
         done_r <= 1'b0;
      end else begin
         done_r <= valid;
         if (valid) begin
            case (op_in)
               OP_LOAD: q_r <= d;
               OP_CLR:  q_r <= '0;
               default: if (is_shift(op_in) && amt_clamp != '0) begin
                  q_r    <= chain_q[amt_clamp];
                  sout_r <= chain_out[amt_clamp];
               end
            endcase
         end
      end
   end
`else
   st_e              state;
   op_e              op_r;
   logic [AW-1:0]    cnt;
   logic [WIDTH-1:0] step_q;
   logic             step_out;

   assign ready = (state == ST_IDLE);

   shift_step #(.WIDTH(WIDTH)) u_step (
      .op      (op_r),
      .sin     (sin),
      .q       (q_r),
      .q_nxt   (step_q),
      .bit_out (step_out)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q_r    <= '0;
         sout_r <= 1'b0;
         done_r <= 1'b0;
         state  <= ST_IDLE;
         op_r   <= OP_NOP;
         cnt    <= '0;
      end else begin
         done_r <= 1'b0;
         case (state)
            ST_IDLE: if (valid) begin
               case (op_in)
                  OP_LOAD: begin q_r <= d;  done_r <= 1'b1; end
                  OP_CLR:  begin q_r <= '0; done_r <= 1'b1; end
                  default: if (is_shift(op_in) && amt_clamp != '0) begin
                     op_r  <= op_in;
                     cnt   <= amt_clamp;
                     state <= ST_RUN;
                  end else begin
                     done_r <= 1'b1;
                  end
               endcase
            end
            ST_RUN: begin
               // Commands presented while running are dropped, not queued.
               q_r    <= step_q;
               sout_r <= step_out;
               cnt    <= cnt - 1'b1;
               if (cnt == AW'(1)) begin
                  state  <= ST_IDLE;
                  done_r <= 1'b1;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end
`endif

endmodule

// File: tb/tb_univ_shift_reg.sv
// Directed bench for univ_shift_reg (WIDTH=8) with an arithmetic reference model.
module tb_univ_shift_reg;

   localparam int W  = 8;
   localparam int AW = $clog2(W+1);
`ifdef SHIFT_FAST_EN
   localparam bit FAST = 1'b1;
`else
   localparam bit FAST = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rst_n;
   logic [W-1:0]  d;
   logic          sin;
   logic [2:0]    op;
   logic [AW-1:0] amt;
   logic          valid;
   logic          ready;
   logic [W-1:0]  q;
   logic [W-1:0]  nq;
   logic          sout;
   logic          done;
   logic          zero;

   univ_shift_reg #(.WIDTH(W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .d     (d),
      .sin   (sin),
      .op    (op),
      .amt   (amt),
      .valid (valid),
      .ready (ready),
      .q     (q),
      .nq    (nq),
      .sout  (sout),
      .done  (done),
      .zero  (zero)
   );

   always #5 clk = ~clk;

   int n_chk  = 0;
   int n_pass = 0;

   task automatic chk(input string nm, input int act, input int exp);
      n_chk++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
   endtask

   // Reference model: final result of a whole command from plain integer arithmetic.
   int m_q = 0, m_sout = 0, m_busy = 0, m_done = 0, mk = 0;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_q = 0; m_sout = 0; m_busy = 0; m_done = 0;
      end else begin
         m_done = 0;
         if (m_busy > 0) begin
            m_busy--;
            if (m_busy == 0) m_done = 1;
         end else if (valid) begin
            mk = (int'(amt) > W) ? W : int'(amt);
            m_done = 1;
            case (op)
               3'd1: m_q = int'(d);
               3'd2: m_q = 0;
               3'd0: ;
               default: if (mk > 0) begin
                  case (op)
                     3'd3: begin
                        m_sout = (m_q >> (W-mk)) & 1;
                        m_q = ((m_q << mk) | (sin ? ((1 << mk) - 1) : 0)) & 255;
                     end
                     3'd4: begin
                        m_sout = (m_q >> (mk-1)) & 1;
                        m_q = (m_q >> mk) | (sin ? (255 & ~(255 >> mk)) : 0);
                     end
                     3'd5: begin
                        m_sout = (m_q >> (mk-1)) & 1;
                        m_q = (m_q >> mk) | (((m_q >> 7) & 1) ? (255 & ~(255 >> mk)) : 0);
                     end
                     3'd6: begin
                        m_sout = (m_q >> (W-mk)) & 1;
                        m_q = ((m_q << mk) | (m_q >> (W-mk))) & 255;
                     end
                     default: begin
                        m_sout = (m_q >> (mk-1)) & 1;
                        m_q = ((m_q >> mk) | (m_q << (W-mk))) & 255;
                     end
                  endcase
                  if (!FAST) begin m_busy = mk; m_done = 0; end
               end
            endcase
         end
      end
   end

   // Every cycle: handshake always; data outputs whenever the register is idle.
   always @(negedge clk) begin
      chk("ready", int'(ready), (m_busy == 0) ? 1 : 0);
      chk("done", int'(done), m_done);
      if (m_busy == 0) begin
         chk("q", int'(q), m_q);
         chk("nq", int'(nq), (~m_q) & 255);
         chk("zero", int'(zero), (m_q == 0) ? 1 : 0);
         chk("sout", int'(sout), m_sout);
      end
   end

   function automatic int ex(input int k);
      return FAST ? 1 : k + 1;
   endfunction

   task automatic wait_done(inout int e);
      while (!done && e < 40) begin @(posedge clk); #1; e++; end
      chk("done_seen", int'(done), 1);
   endtask

   task automatic cmd(input logic [2:0] o, input logic [AW-1:0] a, input logic [W-1:0] dd,
                      input logic s, output int e);
      op = o; amt = a; d = dd; sin = s; valid = 1'b1;
      @(posedge clk); #1;
      valid = 1'b0;
      e = 1;
      wait_done(e);
   endtask

   int e;

   initial begin
      rst_n = 1'b0; valid = 1'b0; op = '0; amt = '0; d = '0; sin = 1'b0;
      repeat (2) @(posedge clk); #1;
      chk("rst_q", int'(q), 0);
      chk("rst_nq", int'(nq), 8'hFF);
      chk("rst_ready", int'(ready), 1);
      chk("rst_done", int'(done), 0);
      chk("rst_sout", int'(sout), 0);
      chk("rst_zero", int'(zero), 1);
      rst_n = 1'b1;
      @(posedge clk); #1;

      cmd(3'd1, 4'd0, 8'hA5, 1'b0, e);
      chk("load_q", int'(q), 8'hA5);
      chk("load_nq", int'(nq), 8'h5A);
      chk("load_zero", int'(zero), 0);
      chk("load_edges", e, 1);
      cmd(3'd0, 4'd5, 8'h00, 1'b0, e);
      chk("nop_q", int'(q), 8'hA5);
      chk("nop_edges", e, 1);

      cmd(3'd1, 4'd0, 8'h81, 1'b0, e);
      cmd(3'd6, 4'd3, 8'h00, 1'b0, e);
      chk("rol3_q", int'(q), 8'h0C);
      chk("rol3_sout", int'(sout), 0);
      chk("rol3_edges", e, ex(3));

      cmd(3'd1, 4'd0, 8'h80, 1'b0, e);
      cmd(3'd5, 4'd9, 8'h00, 1'b0, e);
      chk("asr9_q", int'(q), 8'hFF);
      chk("asr9_sout", int'(sout), 1);
      chk("asr9_edges", e, ex(8));

      cmd(3'd1, 4'd0, 8'h01, 1'b0, e);
      cmd(3'd7, 4'd8, 8'h00, 1'b0, e);
      chk("ror8_q", int'(q), 8'h01);
      chk("ror8_sout", int'(sout), 0);

      cmd(3'd1, 4'd0, 8'h80, 1'b0, e);
      cmd(3'd4, 4'd8, 8'h00, 1'b1, e);
      chk("shr8_q", int'(q), 8'hFF);
      chk("shr8_sout", int'(sout), 1);

      // SHL with a LOAD of zero held on the bus while running.
      cmd(3'd1, 4'd0, 8'h0F, 1'b0, e);
      op = 3'd3; amt = 4'd2; sin = 1'b1; d = 8'h00; valid = 1'b1;
      @(posedge clk); #1;
      e = 1;
      if (!FAST) begin
         op = 3'd1;
         @(posedge clk); #1;
         e++;
      end
      valid = 1'b0;
      wait_done(e);
      chk("shl2_q", int'(q), 8'h3F);
      chk("shl2_sout", int'(sout), 0);
      chk("shl2_edges", e, ex(2));

      // Reset two edges into a 5-step SHR.
      cmd(3'd1, 4'd0, 8'h3D, 1'b0, e);
      op = 3'd4; amt = 4'd5; sin = 1'b0; valid = 1'b1;
      @(posedge clk); #1;
      valid = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b0;
      #1;
      chk("abort_q", int'(q), 0);
      chk("abort_sout", int'(sout), 0);
      chk("abort_ready", int'(ready), 1);
      repeat (2) @(posedge clk);
      #1;
      chk("abort_done", int'(done), 0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      cmd(3'd1, 4'd0, 8'h5A, 1'b0, e);
      cmd(3'd2, 4'd0, 8'h00, 1'b0, e);
      chk("clr_zero", int'(zero), 1);
      chk("clr_edges", e, 1);
      cmd(3'd4, 4'd0, 8'hFF, 1'b1, e);
      chk("shr0_q", int'(q), 0);
      chk("shr0_zero", int'(zero), 1);
      chk("shr0_edges", e, 1);

      repeat (3) @(posedge clk);
      #1;
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
